mc_controller: RTL

Control unit for the multicycle ARM datapath: a Moore state machine that sequences fetch, decode, execute, memory and writeback over several clocks, plus the instruction decoders that drive the shared ALU, register-file write and immediate extender (ImmSrc). It sits beside the datapath and feeds the downstream condition-check unit, which gates RegW/MemW/PCS/NextPC with the flags.

---
 rtl/mc_controller.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mc_controller.sv
// mc_controller: control unit for the multicycle ARM datapath.
// A Moore FSM sequences each instruction through FETCH, DECODE and
// then the memory, data-processing or branch path. Instruction decoders
// alongside it drive the ALU operation, the flag-write enables, the
// immediate extender mode and the register-file read selects.
//
// Ports:
//   clk, reset       rising-edge clock; asynchronous active-high reset (to FETCH)
//   Op, Funct, Rd    Instr[27:26], Instr[25:20], Instr[15:12] from the IR
//   IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, PCS   datapath enables/selects
//   ALUSrcA          0 = A register, 1 = PC
//   ALUSrcB          00 WriteData, 01 ExtImm, 10 constant 4
//   ResultSrc        00 ALUOut, 01 Data, 10 ALUResult
//   ImmSrc           extender mode (equal to Op)
//   RegSrc           register-file read-port selects
//   ALUControl       00 ADD, 01 SUB, 10 AND, 11 ORR
//   FlagW            [1] NZ write, [0] CV write
//   State            current FSM state, for debug/verification
module mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       PCS,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUControl,
  output logic [1:0] FlagW,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic       alu_op;
  logic       no_write;
  logic [3:0] cmd;
  logic       set_flags;

  assign cmd       = Funct[4:1];
  assign set_flags = Funct[0];

  // CMP computes flags only. The IR is held for the whole instruction,
  // so the cmd field seen in ALUWB still belongs to the executing
  // instruction even though the ALU decoder is idle there.
  assign no_write = (cmd == 4'b1010);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Next-state and Moore outputs.
  always_comb begin
    state_d   = FETCH;
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    NextPC    = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    Branch    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    alu_op    = 1'b0;
    case (state_q)
      FETCH: begin
        state_d   = DECODE;
        IRWrite   = 1'b1;
        NextPC    = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        case (Op)
          2'b01:   state_d = MEMADR;
          2'b00:   state_d = Funct[5] ? EXECUTEI : EXECUTER;
          2'b10:   state_d = BRANCH;
          default: state_d = FETCH;  // Op=11: undefined, no effect
        endcase
      end
      MEMADR: begin
        state_d = Funct[0] ? MEMRD : MEMWR;
        ALUSrcB = 2'b01;
      end
      MEMRD: begin
        state_d = MEMWB;
        AdrSrc  = 1'b1;
      end
      MEMWB: begin
        state_d   = FETCH;
        ResultSrc = 2'b01;
        RegW      = 1'b1;
      end
      MEMWR: begin
        state_d = FETCH;
        AdrSrc  = 1'b1;
        MemW    = 1'b1;
      end
      EXECUTER: begin
        state_d = ALUWB;
        alu_op  = 1'b1;
      end
      EXECUTEI: begin
        state_d = ALUWB;
        ALUSrcB = 2'b01;
        alu_op  = 1'b1;
      end
      ALUWB: begin
        state_d = FETCH;
        RegW    = ~no_write;
      end
      BRANCH: begin
        state_d   = FETCH;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        Branch    = 1'b1;
      end
      default: state_d = FETCH;  // codes 10-15: all enables stay 0
    endcase
  end

  // ALU decoder.
  always_comb begin
    ALUControl = 2'b00;
    FlagW      = 2'b00;
    if (alu_op) begin
      case (cmd)
        4'b0100: begin ALUControl = 2'b00; FlagW = {set_flags, set_flags}; end
        4'b0010: begin ALUControl = 2'b01; FlagW = {set_flags, set_flags}; end
        4'b0000: begin ALUControl = 2'b10; FlagW = {set_flags, 1'b0};      end
        4'b1100: begin ALUControl = 2'b11; FlagW = {set_flags, 1'b0};      end
        4'b1010: begin ALUControl = 2'b01; FlagW = {set_flags, set_flags}; end
        default: begin ALUControl = 2'b00; FlagW = 2'b00;                  end
      endcase
    end
  end

  // Instruction decoder: state-independent.
  assign ImmSrc = Op;
  assign RegSrc = {(Op == 2'b01), (Op == 2'b10)};

  // A write to R15 or a branch redirects the PC.
  assign PCS   = ((Rd == 4'hF) & RegW) | Branch;
  assign State = state_q;

endmodule
